tone_gen: RTL and testbench

Reference-tone generator for the guitar tuner: converts a period in nanoseconds into a square wave on a single pin. It is the transmit counterpart of the period-measurement path. It uses the same ns units and the same 10 MHz (100 ns) clock, so a measured period can be fed straight back to produce an audible or loop-back reference. Period changes are glitch-free and take effect only at a full-cycle boundary. Long-run frequency accuracy comes from fractional-ns accumulation.

---
 rtl/tone_gen.sv | 192 +++++++++++++++++++
 tb/tb_tone_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// Reference square-wave generator: turns a period in ns into a glitch-free tone on one pin.
// Optional rising-edge counter is built when TONE_GEN_EDGE_COUNT_EN is defined.
module tone_gen #(
  parameter int unsigned CLK_NS        = 100,
  parameter int unsigned MIN_PERIOD_NS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [33:0] period_in,
  input  logic        load,
  output logic        wave,
  output logic        rise,
  output logic        active,
  output logic        range_err
`ifdef TONE_GEN_EDGE_COUNT_EN
  ,
  output logic [15:0] edge_count
`endif
);

  localparam logic [33:0] ClkStep   = 34'(CLK_NS);
  localparam logic [33:0] MinPeriod = 34'(MIN_PERIOD_NS);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [32:0] cur_half_q, cur_half_d;
  logic [32:0] pend_half_q, pend_half_d;
  logic        pend_valid_q, pend_valid_d;
  logic [33:0] acc_q, acc_d;
  logic        wave_q, wave_d;
  logic        rise_q, rise_d;
  logic        range_err_q, range_err_d;

  logic [33:0] acc_sum;
  logic [33:0] half_ext;
  logic [33:0] acc_wrap;
  logic        term;
  logic        load_stop;
  logic        load_rej;
  logic        load_ok;

  // acc < cur_half is invariant, so the sum and the residue both fit in 34 bits.
  assign acc_sum  = acc_q + ClkStep;
  assign half_ext = {1'b0, cur_half_q};
  assign acc_wrap = acc_sum - half_ext;
  assign term     = (acc_sum >= half_ext);

  assign load_stop = load && (period_in == '0);
  assign load_rej  = load && (period_in != '0) && (period_in < MinPeriod);
  assign load_ok   = load && (period_in >= MinPeriod);

  always_comb begin
    state_d      = state_q;
    cur_half_d   = cur_half_q;
    pend_half_d  = pend_half_q;
    pend_valid_d = pend_valid_q;
    acc_d        = acc_q;
    wave_d       = wave_q;
    rise_d       = 1'b0;
    range_err_d  = range_err_q;

    unique case (state_q)
      StIdle: begin
        wave_d = 1'b0;
        acc_d  = '0;
        if (pend_valid_q) begin
          pend_valid_d = 1'b0;
          if (pend_half_q != '0) begin
            cur_half_d = pend_half_q;
            wave_d     = 1'b1;
            rise_d     = 1'b1;
            state_d    = StHigh;
          end
        end
      end

      StHigh: begin
        if (term) begin
          acc_d   = acc_wrap;
          wave_d  = 1'b0;
          state_d = StLow;
        end else begin
          acc_d = acc_sum;
        end
      end

      StLow: begin
        if (!term) begin
          acc_d = acc_sum;
        end else if (!pend_valid_q) begin
          // Residue carries into the next half so the long-run average stays exact.
          acc_d   = acc_wrap;
          wave_d  = 1'b1;
          rise_d  = 1'b1;
          state_d = StHigh;
        end else if (pend_half_q != '0) begin
          cur_half_d   = pend_half_q;
          acc_d        = '0;
          pend_valid_d = 1'b0;
          wave_d       = 1'b1;
          rise_d       = 1'b1;
          state_d      = StHigh;
        end else begin
          acc_d        = '0;
          pend_valid_d = 1'b0;
          wave_d       = 1'b0;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        acc_d   = '0;
        wave_d  = 1'b0;
      end
    endcase

    // A load in the adoption cycle lands after adoption consumed the old pending value.
    if (load_stop) begin
      pend_half_d  = '0;
      pend_valid_d = 1'b1;
    end else if (load_rej) begin
      range_err_d = 1'b1;
    end else if (load_ok) begin
      pend_half_d  = period_in[33:1];
      pend_valid_d = 1'b1;
      range_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_half_q   <= '0;
      pend_half_q  <= '0;
      pend_valid_q <= 1'b0;
      acc_q        <= '0;
      wave_q       <= 1'b0;
      rise_q       <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_half_q   <= cur_half_d;
      pend_half_q  <= pend_half_d;
      pend_valid_q <= pend_valid_d;
      acc_q        <= acc_d;
      wave_q       <= wave_d;
      rise_q       <= rise_d;
      range_err_q  <= range_err_d;
    end
  end

  assign wave      = wave_q;
  assign rise      = rise_q;
  assign active    = (state_q != StIdle);
  assign range_err = range_err_q;

`ifdef TONE_GEN_EDGE_COUNT_EN
  logic [15:0] edge_count_q, edge_count_d;

  always_comb begin
    edge_count_d = edge_count_q;
    if (rise_d) begin
      edge_count_d = edge_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_count_q <= '0;
    end else begin
      edge_count_q <= edge_count_d;
    end
  end

  assign edge_count = edge_count_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && (state_q != StIdle)) begin
      assert (acc_q < half_ext);
    end
  end
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: vector table plus a run-length scoreboard on wave.
module tb_tone_gen;

  logic        clk;
  logic        rst;
  logic [33:0] period_in;
  logic        load;
  logic        wave;
  logic        rise;
  logic        active;
  logic        range_err;
`ifdef TONE_GEN_EDGE_COUNT_EN
  logic [15:0] edge_count;
`endif

  tone_gen dut (
    .clk       (clk),
    .rst       (rst),
    .period_in (period_in),
    .load      (load),
    .wave      (wave),
    .rise      (rise),
    .active    (active),
    .range_err (range_err)
`ifdef TONE_GEN_EDGE_COUNT_EN
    ,
    .edge_count(edge_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] period;
    logic        err;
    int          r0;
    int          r1;
    int          r2;
    int          r3;
  } vec_t;

  typedef struct packed {
    logic        level;
    logic [15:0] len;
  } run_t;

  vec_t vecs [9];
  run_t sb_q [$];
  bit   sb_en;
  int   checks;
  int   errors;
  int   rise_cnt;
  int   run_len;
  logic prev_wave;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_run(input logic lvl, input int len);
    run_t r;
    r.level = lvl;
    r.len   = 16'(len);
    sb_q.push_back(r);
  endtask

  task automatic push_cycle(input int h0, input int l0, input int h1, input int l1);
    push_run(1'b1, h0);
    push_run(1'b0, l0);
    push_run(1'b1, h1);
    push_run(1'b0, l1);
  endtask

  task automatic apply_reset();
    sb_en = 1'b0;
    sb_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Load is sampled on the posedge between the two negedges.
  task automatic do_load(input logic [33:0] p);
    @(negedge clk);
    period_in = p;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rise === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chki({name, " runs outstanding"}, sb_q.size(), 0);
  endtask

  // Monitor: rise must equal a 0->1 wave step; finished wave runs are scored.
  always @(negedge clk) begin
    run_t e;
    checks++;
    if (rise !== (wave & ~prev_wave)) begin
      errors++;
      $display("FAIL rise_vs_wave: rise %b wave %b prev %b", rise, wave, prev_wave);
    end
    if (rise === 1'b1) rise_cnt++;
    if (wave !== prev_wave) begin
      if (sb_en && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (prev_wave !== e.level || (e.len != 0 && run_len != int'(e.len))) begin
          errors++;
          $display("FAIL wave_run: level %b len %0d expected level %b len %0d",
                   prev_wave, run_len, e.level, e.len);
        end
      end
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_wave = wave;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bit ok;
    int base;
    int sum;
    checks    = 0;
    errors    = 0;
    rise_cnt  = 0;
    run_len   = 0;
    prev_wave = 1'b0;
    sb_en     = 1'b0;
    rst       = 1'b0;
    load      = 1'b0;
    period_in = '0;

    vecs[0] = '{period: 34'd1000, err: 1'b0, r0: 5, r1: 5, r2: 5, r3: 5};
    vecs[1] = '{period: 34'd250,  err: 1'b0, r0: 2, r1: 1, r2: 1, r3: 1};
    vecs[2] = '{period: 34'd350,  err: 1'b0, r0: 2, r1: 2, r2: 2, r3: 1};
    vecs[3] = '{period: 34'd600,  err: 1'b0, r0: 3, r1: 3, r2: 3, r3: 3};
    vecs[4] = '{period: 34'd200,  err: 1'b0, r0: 1, r1: 1, r2: 1, r3: 1};
    vecs[5] = '{period: 34'd1001, err: 1'b0, r0: 5, r1: 5, r2: 5, r3: 5};
    vecs[6] = '{period: 34'd150,  err: 1'b1, r0: 0, r1: 0, r2: 0, r3: 0};
    vecs[7] = '{period: 34'd199,  err: 1'b1, r0: 0, r1: 0, r2: 0, r3: 0};
    vecs[8] = '{period: 34'd0,    err: 1'b0, r0: 0, r1: 0, r2: 0, r3: 0};

    #1;
    apply_reset();
    chk1("reset wave", wave, 1'b0);
    chk1("reset rise", rise, 1'b0);
    chk1("reset active", active, 1'b0);
    chk1("reset range_err", range_err, 1'b0);
`ifdef TONE_GEN_EDGE_COUNT_EN
    chki("reset edge_count", int'(edge_count), 0);
`endif

    for (int i = 0; i < 9; i++) begin
      apply_reset();
      if (vecs[i].r0 != 0) begin
        push_run(1'b0, 0);
        push_cycle(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3);
        push_cycle(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3);
        sb_en = 1'b1;
      end
      do_load(vecs[i].period);
      chk1($sformatf("vec%0d range_err", i), range_err, vecs[i].err);
      if (vecs[i].r0 != 0) begin
        sum = vecs[i].r0 + vecs[i].r1 + vecs[i].r2 + vecs[i].r3;
        wait_drain($sformatf("vec%0d", i), 2 * sum + 10);
        chk1($sformatf("vec%0d active", i), active, 1'b1);
      end else begin
        repeat (6) @(negedge clk);
        chk1($sformatf("vec%0d wave idle", i), wave, 1'b0);
        chk1($sformatf("vec%0d active idle", i), active, 1'b0);
      end
      sb_en = 1'b0;
    end

    // Latency from load to first rise, then the third rise 20 cycles later.
    apply_reset();
    do_load(34'd1000);
    chk1("lat wave before", wave, 1'b0);
    chk1("lat active before", active, 1'b0);
    @(negedge clk);
    chk1("lat wave rise", wave, 1'b1);
    chk1("lat rise pulse", rise, 1'b1);
    chk1("lat active", active, 1'b1);
    @(negedge clk);
    chk1("lat rise width", rise, 1'b0);
    repeat (19) @(negedge clk);
    chk1("lat third rise", rise, 1'b1);
`ifdef TONE_GEN_EDGE_COUNT_EN
    chki("edge_count after 3 rises", int'(edge_count), 3);
`endif

    // Period change mid-HIGH completes the current cycle first.
    apply_reset();
    push_run(1'b0, 0);
    push_cycle(5, 5, 2, 2);
    push_run(1'b1, 2);
    push_run(1'b0, 2);
    sb_en = 1'b1;
    do_load(34'd1000);
    wait_rise(ok);
    chk1("chg rise seen", ok, 1'b1);
    @(negedge clk);
    do_load(34'd400);
    wait_drain("chg", 40);
    sb_en = 1'b0;

    // Rejected load while running leaves the tone alone; a good one then clears the flag.
    apply_reset();
    push_run(1'b0, 0);
    push_cycle(5, 5, 3, 3);
    push_run(1'b1, 3);
    push_run(1'b0, 3);
    sb_en = 1'b1;
    do_load(34'd1000);
    wait_rise(ok);
    chk1("rej rise seen", ok, 1'b1);
    @(negedge clk);
    do_load(34'd150);
    chk1("rej range_err set", range_err, 1'b1);
    chk1("rej wave kept", wave, 1'b1);
    do_load(34'd600);
    chk1("rej range_err clear", range_err, 1'b0);
    wait_drain("rej", 40);
    sb_en = 1'b0;

    // Stop finishes the LOW phase and then stays quiet.
    apply_reset();
    push_run(1'b0, 0);
    push_run(1'b1, 5);
    sb_en = 1'b1;
    do_load(34'd1000);
    wait_rise(ok);
    chk1("stop rise seen", ok, 1'b1);
    @(negedge clk);
    do_load(34'd0);
    repeat (5) @(negedge clk);
    chk1("stop still active in low", active, 1'b1);
    chk1("stop wave low", wave, 1'b0);
    base = rise_cnt;
    repeat (20) @(negedge clk);
    chk1("stop wave idle", wave, 1'b0);
    chk1("stop active idle", active, 1'b0);
    chki("stop no more rises", rise_cnt, base);
    wait_drain("stop", 2);
    sb_en = 1'b0;

    // Async reset mid-HIGH.
    apply_reset();
    do_load(34'd1000);
    wait_rise(ok);
    chk1("rst rise seen", ok, 1'b1);
    @(negedge clk);
    do_load(34'd150);
    chk1("rst pre range_err", range_err, 1'b1);
    chk1("rst pre wave", wave, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("rst async wave", wave, 1'b0);
    chk1("rst async rise", rise, 1'b0);
    chk1("rst async active", active, 1'b0);
    chk1("rst async range_err", range_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk1("rst idle wave", wave, 1'b0);
    chk1("rst idle active", active, 1'b0);
`ifdef TONE_GEN_EDGE_COUNT_EN
    chki("rst edge_count", int'(edge_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
